regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have these ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: p_valid  input  1 / p_idx  input  5 / p_data  input  32  pipeline writeback request.
REQ-004 SHALL have: p_ready  output  1  pipeline request accepted this cycle.
REQ-005 SHALL have: m_valid  input  1 / m_idx  input  5 / m_data  input  32  multi-cycle unit (load/div) writeback request.
REQ-006 SHALL have: m_ready  output  1  multi-cycle request accepted this cycle.
REQ-007 SHALL have: iss_valid  input  1 / iss_idx  input  5  long-latency op issued with destination iss_idx.
REQ-008 SHALL have: chk_rs1_idx, chk_rs2_idx, chk_rd_idx  input  5 each  decode-stage operands to check.
REQ-009 SHALL have: stall  output  1  decode must hold.
REQ-010 SHALL have: rf_reg_write  output  1 / rf_rd_idx  output  5 / rf_rd_data  output  32  registered register-file write port.
REQ-011 SHALL have: busy_vec  output  32  scoreboard state, bit i = register i pending.

Function
REQ-012 SHALL transfer a request when valid && ready on the same rising edge; requesters hold valid/idx/data stable until accepted.
REQ-013 SHALL grant at most one requester per cycle; p_ready and m_ready SHALL be combinational from valids and grant state, never both 1.
REQ-014 SHALL grant the sole valid requester when only one is valid.
REQ-015 SHALL, when both valid, grant the requester not recorded in last_grant; last_grant updates to the granted requester on every transfer.
REQ-016 SHALL present an accepted request on rf_* one cycle after acceptance (latency 1): rf_reg_write=1, rf_rd_idx=idx, rf_rd_data=data.
REQ-017 SHALL drive rf_reg_write=0 in cycles following no transfer; rf_rd_idx/rf_rd_data hold last values.
REQ-018 SHALL accept idx==0 requests normally but drive rf_reg_write=0 for them.
REQ-019 SHALL set busy_vec[iss_idx] on an edge with iss_valid=1 and iss_idx!=0.
REQ-020 SHALL clear busy_vec[m_idx] on an edge where the m transfer occurs.
REQ-021 SHALL, on simultaneous set and clear of the same index, leave the bit set (new issue wins).
REQ-022 SHALL hold busy_vec[0]=0 always.
REQ-023 SHALL drive stall = busy[chk_rs1_idx] | busy[chk_rs2_idx] | busy[chk_rd_idx] | (p_valid && !p_ready), combinationally.
REQ-024 SHALL not forward write data; the register file handles same-cycle bypass.

Reset
REQ-025 SHALL, while rst=1, clear busy_vec, rf_reg_write, rf_rd_idx, rf_rd_data to 0 and set last_grant=m (pipeline wins first contention).
REQ-026 SHALL hold p_ready=m_ready=0 and stall=0 while rst=1; requests present during reset are not accepted and iss_valid is ignored.
REQ-027 SHALL discard an in-flight (accepted, not yet written) request when rst asserts mid-operation; rf_reg_write=0 the cycle after.

Configuration
REQ-028 SHALL define WB_ARB_ROUND_ROBIN_EN: when defined, arbitration per REQ-015.
REQ-029 SHALL, when WB_ARB_ROUND_ROBIN_EN is undefined, use fixed priority p over m on contention, with last_grant removed; all other behaviour unchanged.

Verification
REQ-030 SHALL cover: single request p_valid=1, p_idx=5, p_data=0xDEADBEEF -> p_ready=1 same cycle; next cycle rf_reg_write=1, rf_rd_idx=5, rf_rd_data=0xDEADBEEF.
REQ-031 SHALL cover: both valid for 4 cycles after reset (p_idx=1, m_idx=2), RR build -> grants p,m,p,m; fixed build -> p every cycle, m_ready=0.
REQ-032 SHALL cover: iss_valid=1, iss_idx=7; next cycle chk_rs1_idx=7 -> stall=1; m transfer with m_idx=7 -> busy_vec[7]=0, stall=0 next cycle.
REQ-033 SHALL cover: same edge iss_idx=9 and m transfer m_idx=9 with busy_vec[9]=1 -> busy_vec[9] remains 1.
REQ-034 SHALL cover: p_valid=1, p_idx=0 -> p_ready=1, next cycle rf_reg_write=0; iss_idx=0 -> busy_vec stays 0.
REQ-035 SHALL cover: rst asserted the cycle after acceptance of m_idx=3 with busy_vec[3]=1 -> next cycle rf_reg_write=0, busy_vec=0, ready outputs 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the pipeline, multi-cycle units, decode checks and the register file.
// The arbiter uses the slave modport. The requesters and decode use the master modport.
interface regfile_wb_arbiter_if;
  logic        p_valid;
  logic [4:0]  p_idx;
  logic [31:0] p_data;
  logic        p_ready;

  logic        m_valid;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic        m_ready;

  logic        iss_valid;
  logic [4:0]  iss_idx;

  logic [4:0]  chk_rs1_idx;
  logic [4:0]  chk_rs2_idx;
  logic [4:0]  chk_rd_idx;
  logic        stall;

  logic        rf_reg_write;
  logic [4:0]  rf_rd_idx;
  logic [31:0] rf_rd_data;
  logic [31:0] busy_vec;

  modport master (
    output p_valid, p_idx, p_data,
    input  p_ready,
    output m_valid, m_idx, m_data,
    input  m_ready,
    output iss_valid, iss_idx,
    output chk_rs1_idx, chk_rs2_idx, chk_rd_idx,
    input  stall,
    input  rf_reg_write, rf_rd_idx, rf_rd_data, busy_vec
  );

  modport slave (
    input  p_valid, p_idx, p_data,
    output p_ready,
    input  m_valid, m_idx, m_data,
    output m_ready,
    input  iss_valid, iss_idx,
    input  chk_rs1_idx, chk_rs2_idx, chk_rd_idx,
    output stall,
    output rf_reg_write, rf_rd_idx, rf_rd_data, busy_vec
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter with a long-latency scoreboard, in front of a single register-file write port.
// Define WB_ARB_ROUND_ROBIN_EN to alternate between requesters on contention. When it is undefined, the pipeline has fixed priority.
module regfile_wb_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   wb
);

  typedef enum logic {
    GRANT_P = 1'b0,
    GRANT_M = 1'b1
  } grant_e;

  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    onehot32 = 32'd1 << idx;
  endfunction

  logic        p_ready_s;
  logic        m_ready_s;
  logic        prefer_p_s;
  logic        stall_s;

  logic        wr_en_s;
  logic [4:0]  wr_idx_s;
  logic [31:0] wr_data_s;
  logic        rf_reg_write_r;
  logic [4:0]  rf_rd_idx_r;
  logic [31:0] rf_rd_data_r;

  logic [31:0] busy_r;
  logic [31:0] busy_next_s;
  logic [31:0] clr_mask_s;
  logic [31:0] set_mask_s;

`ifdef WB_ARB_ROUND_ROBIN_EN
  grant_e last_grant_r;

  // Track the most recent winner so that the other requester wins the next contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= GRANT_M;
    end else if (p_ready_s) begin
      last_grant_r <= GRANT_P;
    end else if (m_ready_s) begin
      last_grant_r <= GRANT_M;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // The pipeline is preferred only when the multi-cycle unit won last.
  always_comb begin
    prefer_p_s = (last_grant_r == GRANT_M);
  end
`else
  // Fixed priority: the pipeline always wins contention.
  always_comb begin
    prefer_p_s = 1'b1;
  end
`endif

  // Grant at most one requester. During reset, grant nothing.
  always_comb begin
    p_ready_s = 1'b0;
    m_ready_s = 1'b0;
    if (rst) begin
      p_ready_s = 1'b0;
      m_ready_s = 1'b0;
    end else begin
      case ({wb.p_valid, wb.m_valid})
        2'b10:   p_ready_s = 1'b1;
        2'b01:   m_ready_s = 1'b1;
        2'b11: begin
          if (prefer_p_s) begin
            p_ready_s = 1'b1;
          end else begin
            m_ready_s = 1'b1;
          end
        end
        default: begin
          p_ready_s = 1'b0;
          m_ready_s = 1'b0;
        end
      endcase
    end
  end

  // Select the accepted request for the write port. Index 0 is accepted but never written.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = rf_rd_idx_r;
    wr_data_s = rf_rd_data_r;
    if (p_ready_s) begin
      wr_en_s   = (wb.p_idx != 5'd0);
      wr_idx_s  = wb.p_idx;
      wr_data_s = wb.p_data;
    end else if (m_ready_s) begin
      wr_en_s   = (wb.m_idx != 5'd0);
      wr_idx_s  = wb.m_idx;
      wr_data_s = wb.m_data;
    end else begin
      wr_en_s   = 1'b0;
      wr_idx_s  = rf_rd_idx_r;
      wr_data_s = rf_rd_data_r;
    end
  end

  // Register the write port. The pulse lasts one cycle, and the index and data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_reg_write_r <= 1'b0;
      rf_rd_idx_r    <= 5'd0;
      rf_rd_data_r   <= 32'd0;
    end else begin
      rf_reg_write_r <= wr_en_s;
      rf_rd_idx_r    <= wr_idx_s;
      rf_rd_data_r   <= wr_data_s;
    end
  end

  // Scoreboard update. The set is applied after the clear, so a new issue wins over a completion to the same index.
  always_comb begin
    clr_mask_s  = m_ready_s ? onehot32(wb.m_idx) : 32'd0;
    set_mask_s  = (wb.iss_valid && (wb.iss_idx != 5'd0)) ? onehot32(wb.iss_idx) : 32'd0;
    busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  end

  // Scoreboard register. Issues seen during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Decode hazard: a pending operand, or a pipeline writeback that lost arbitration.
  always_comb begin
    stall_s = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else begin
      stall_s = busy_r[wb.chk_rs1_idx] | busy_r[wb.chk_rs2_idx] | busy_r[wb.chk_rd_idx]
              | (wb.p_valid & ~p_ready_s);
    end
  end

  // Drive the interface outputs.
  always_comb begin
    wb.p_ready      = p_ready_s;
    wb.m_ready      = m_ready_s;
    wb.stall        = stall_s;
    wb.rf_reg_write = rf_reg_write_r;
    wb.rf_rd_idx    = rf_rd_idx_r;
    wb.rf_rd_data   = rf_rd_data_r;
    wb.busy_vec     = busy_r;
  end

endmodule
